// File: rtl/asic_spike_classifier_pkg.sv
// Shared types and constants for the ASIC output-neuron spike classifier.
// Holds the FSM encoding, default counter width and the XADC code field position.
package asic_spike_classifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_DECIDE  = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int CODE_W    = 12;
  localparam int CODE_MSB  = 15;
  localparam int CODE_LSB  = 4;

  // The XADC DO register left-justifies its 12-bit conversion result.
  function automatic logic [CODE_W-1:0] xadc_code(input logic [15:0] do_word);
    return do_word[CODE_MSB:CODE_LSB];
  endfunction

endpackage

// File: rtl/asic_spike_classifier_spike_counter_ch.sv
// One neuron channel: hysteresis spike detector feeding a saturating counter.
// The flag survives counter clears so a pulse straddling windows counts once.
module spike_counter_ch
  import asic_spike_classifier_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_cnt,
  input  logic              clr_flag,
  input  logic              sample_en,
  input  logic [CODE_W-1:0] code,
  input  logic [CODE_W-1:0] thresh_hi,
  input  logic [CODE_W-1:0] thresh_lo,
  output logic [CNT_W-1:0]  count
);

  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (clr_flag) flag_d = 1'b0;
    if (clr_cnt)  cnt_d  = '0;
    if (sample_en) begin
      if (!flag_q && (code >= thresh_hi)) begin
        flag_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else if (flag_q && (code < thresh_lo)) begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/asic_spike_classifier.sv
// Windowed spike-count classifier: counts hysteresis-qualified spikes per XADC
// channel over window_len cycles and reports the channel with the most spikes.
module asic_spike_classifier
  import asic_spike_classifier_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BASE = 16,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [4:0]        sample_channel,
  input  logic [15:0]       sample_data,
  input  logic [CODE_W-1:0] thresh_hi,
  input  logic [CODE_W-1:0] thresh_lo,
  input  logic [15:0]       window_len,
  output logic [1:0]        network_output,
  output logic              result_valid,
  output logic              no_spike
);

  state_e      state_q, state_d;
  logic [15:0] win_q, win_d;
  logic [15:0] win_last;
  logic [1:0]  out_q, out_d;
  logic        rv_q, rv_d;
  logic        ns_q, ns_d;

  logic [CODE_W-1:0]             code;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_all;
  logic                          acq, clr_cnt, clr_flag;
  logic [1:0]                    best_idx;
  logic [CNT_W-1:0]              best_cnt;
  logic                          any_spike;

  assign code     = xadc_code(sample_data);
  assign acq      = (state_q == ST_ACQUIRE);
  assign clr_cnt  = (state_q == ST_IDLE) || (state_q == ST_DECIDE);
  assign clr_flag = (state_q == ST_IDLE);
  // A zero window length behaves as a one-cycle window.
  assign win_last = (window_len == 16'd0) ? 16'd0 : window_len - 16'd1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      localparam logic [4:0] CH_ID = 5'(CH_BASE + gi);
      spike_counter_ch #(.CNT_W(CNT_W)) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_cnt   (clr_cnt),
        .clr_flag  (clr_flag),
        .sample_en (acq && sample_valid && (sample_channel == CH_ID)),
        .code      (code),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .count     (cnt_all[gi])
      );
    end
  endgenerate

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cnt_all[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (cnt_all[i] > best_cnt) begin
        best_cnt = cnt_all[i];
        best_idx = 2'(i);
      end
    end
    any_spike = |cnt_all;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    out_d   = out_q;
    ns_d    = ns_q;
    rv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        win_d = 16'd0;
        if (enable) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          win_d   = 16'd0;
        end else if (win_q == win_last) begin
          state_d = ST_DECIDE;
          win_d   = 16'd0;
        end else begin
          win_d = win_q + 16'd1;
        end
      end
      ST_DECIDE: begin
        rv_d  = 1'b1;
        ns_d  = !any_spike;
        win_d = 16'd0;
        if (any_spike) out_d = best_idx;
        state_d = enable ? ST_ACQUIRE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        win_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 16'd0;
      out_q   <= 2'd0;
      rv_q    <= 1'b0;
      ns_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      out_q   <= out_d;
      rv_q    <= rv_d;
      ns_q    <= ns_d;
    end
  end

  assign network_output = out_q;
  assign result_valid   = rv_q;
  assign no_spike       = ns_q;

endmodule
